// File: rtl/fetch_controller.sv
// Fetch/decode sequencer for the PC + program ROM + fetch-register datapath.
// Handles single-byte instructions, two-byte JMP/JZ, and HALT.
module fetch_controller #(
  parameter int unsigned ADDR_W  = 12,
  parameter logic [3:0]  OP_JMP  = 4'b1100,
  parameter logic [3:0]  OP_JZ   = 4'b1101,
  parameter logic [3:0]  OP_HALT = 4'b1111
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              run,
  input  logic [3:0]        instr,
  input  logic [3:0]        operand,
  input  logic              zero_flag,
  output logic              en_pc,
  output logic              en_fetch,
  output logic              load_pc,
  output logic [ADDR_W-1:0] load_addr,
  output logic              exec_valid,
  output logic              halted,
  output logic [7:0]        retired,
  output logic [2:0]        state_dbg
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    JFETCH = 3'd4,
    JLOAD  = 3'd5,
    HALT   = 3'd6
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        target_hi_q, target_hi_d;
  logic              jz_pending_q, jz_pending_d;
  logic [7:0]        retired_q, retired_d;
  logic [ADDR_W-1:0] load_addr_q, load_addr_d;

  logic [ADDR_W-1:0] jmp_tgt;
  logic [7:0]        retired_inc;
  logic              take;

  // Jump target: high nibble from the first byte, low byte from the second.
  assign jmp_tgt     = ADDR_W'({target_hi_q, instr, operand});
  assign retired_inc = (retired_q == 8'hFF) ? retired_q : retired_q + 8'd1;
  assign take        = !jz_pending_q || zero_flag;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      target_hi_q  <= '0;
      jz_pending_q <= 1'b0;
      retired_q    <= '0;
      load_addr_q  <= '0;
    end else begin
      state_q      <= state_d;
      target_hi_q  <= target_hi_d;
      jz_pending_q <= jz_pending_d;
      retired_q    <= retired_d;
      load_addr_q  <= load_addr_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    target_hi_d  = target_hi_q;
    jz_pending_d = jz_pending_q;
    retired_d    = retired_q;
    load_addr_d  = load_addr_q;
    en_pc        = 1'b0;
    en_fetch     = 1'b0;
    load_pc      = 1'b0;
    load_addr    = load_addr_q;
    exec_valid   = 1'b0;
    halted       = 1'b0;

    case (state_q)
      IDLE: begin
        if (run) state_d = FETCH;
      end
      FETCH: begin
        en_fetch = 1'b1;
        en_pc    = 1'b1;
        state_d  = DECODE;
      end
      DECODE: begin
        if (instr == OP_HALT) begin
          state_d = HALT;
        end else if (instr == OP_JMP || instr == OP_JZ) begin
          target_hi_d  = operand;
          jz_pending_d = (instr == OP_JZ);
          state_d      = JFETCH;
        end else begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        exec_valid = 1'b1;
        retired_d  = retired_inc;
        state_d    = run ? FETCH : IDLE;
      end
      JFETCH: begin
        en_fetch = 1'b1;
        en_pc    = 1'b1;
        state_d  = JLOAD;
      end
      JLOAD: begin
        // Not-taken needs no PC action: JFETCH already stepped past byte 2.
        load_addr   = jmp_tgt;
        load_addr_d = jmp_tgt;
        en_pc       = take;
        load_pc     = take;
        retired_d   = retired_inc;
        state_d     = run ? FETCH : IDLE;
      end
      HALT: begin
        halted = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  assign retired   = retired_q;
  assign state_dbg = state_q;

endmodule
